if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of `id`. Owns the PC, issues single-outstanding requests to a variable-latency instruction memory, and delivers `{pc, inst}` pairs to `id` through a registered IF/ID boundary. Supports pipeline stall, IF/ID flush and PC redirect from later stages; a redirect never aborts an in-flight memory request, it drains it.

## Interface
- `N_INST_ADDR`, 32, PC / instruction address width.
- `N_INST_DATA`, 32, instruction width.
- `RESET_PC`, 0, first fetch address; bits [1:0] must be 0.

- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_stall`  in  1  hold IF/ID register and block delivery.
- `i_flush`  in  1  replace IF/ID contents with a bubble.
- `i_redirect_en`  in  1  load new fetch PC.
- `i_redirect_addr`  in  N_INST_ADDR  redirect target; bits [1:0] ignored (forced 0).
- `o_imem_req`  out  1  fetch request.
- `o_imem_addr`  out  N_INST_ADDR  fetch address.
- `i_imem_ack`  in  1  one-cycle response strobe; data valid in the same cycle.
- `i_imem_data`  in  N_INST_DATA  fetched instruction.
- `o_id_valid`  out  1  IF/ID holds a real instruction.
- `o_id_pc`  out  N_INST_ADDR  PC to `id.i_pc`.
- `o_id_inst`  out  N_INST_DATA  instruction to `id.i_inst`; 0 (NOP) when invalid.

## Operation
- State: `pc`, `redir_pc`, hold buffer `{buf_pc, buf_inst}`, IF/ID register, FSM.
- FSM states: S_RESET, S_FETCH, S_HOLD, S_DRAIN.
- `o_imem_req` = (S_FETCH or S_DRAIN); `o_imem_addr` = `pc`; both combinational from state. Address stays stable while req is high and no ack.
- "Accept" = ack in S_FETCH with no redirect in the same cycle.
- S_RESET: → S_FETCH. Redirect here sets `pc`.
- S_FETCH, accept, `!i_stall`: IF/ID <= {valid=1, pc, data}; `pc` <= `pc`+4; stay.
- S_FETCH, accept, `i_stall`: buffer <= {pc, data}; `pc` <= `pc`+4; → S_HOLD.
- S_FETCH, redirect with ack: data discarded; `pc` <= target; stay.
- S_FETCH, redirect without ack: `redir_pc` <= target; → S_DRAIN.
- S_DRAIN: further redirects overwrite `redir_pc`, latest wins. On ack: data discarded; `pc` <= `redir_pc`; → S_FETCH.
- S_HOLD: req low. Redirect: buffer discarded; `pc` <= target; → S_FETCH, even if stalled. Else when `!i_stall`: IF/ID <= buffer; → S_FETCH.
- IF/ID update, highest priority first:
  - `i_flush`: bubble (valid=0, pc=0, inst=0), regardless of stall. A concurrent accept or HOLD release still loads the buffer / advances `pc` as if stalled, so no instruction is lost.
  - `i_stall`: hold.
  - Delivery (accept or HOLD release): load as above.
  - Otherwise: bubble.
- PC arithmetic: modulo 2^N_INST_ADDR; 0xFFFF_FFFC + 4 = 0.

## Timing
- Reset (async, immediate): state=S_RESET, `pc`=RESET_PC, `o_imem_req`=0, `o_imem_addr`=RESET_PC, `o_id_valid`=0, `o_id_pc`=0, `o_id_inst`=0, buffer and `redir_pc`=0.
- Reset deassert at edge 0: req high after edge 1.
- Ack in cycle k: `o_id_*` valid after edge k+1. The next request address is presented in cycle k+1.
- Zero-wait memory (ack every cycle req is high): one instruction per cycle.
- Exactly one request outstanding; the memory must not ack when req is low.
- Asserting reset mid-request drops req immediately; the memory must abandon the transaction.

## Test plan
- Zero-wait memory returning `0x3400_0000|addr`; reset released → req at addr 0 one cycle later; `o_id_pc` = 0, 4, 8 on consecutive cycles; first valid two cycles after release.
- Memory with 2 wait cycles → addr held 3 cycles; `o_id_valid`=0 and `o_id_inst`=0 between instructions; one instruction per 3 cycles.
- Stall held 3 cycles from the ack of pc 8 → req low, IF/ID keeps pc 4. On release: `o_id_pc`=8 next cycle, then req at 0xC.
- Redirect to 0x100 while 0x10 is pending with 2 wait cycles → addr stays 0x10 until ack; data discarded; next req 0x100; pc 0x10 never reaches `o_id`.
- `i_flush` together with `i_stall` → `o_id_valid`=0, `o_id_inst`=0 next cycle. Redirect in S_HOLD → buffered instruction never delivered.
- `RESET_PC`=0xFFFF_FFF8 → fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Async reset mid-wait → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage of the five-stage MIPS pipeline. Owns the
//            fetch PC, keeps a single request outstanding to a variable-latency
//            instruction memory and hands {pc, inst} pairs to the decode stage
//            through a registered IF/ID boundary. Supports stall, IF/ID flush
//            and PC redirect. A redirect never aborts an in-flight memory
//            request: the request is drained and its data dropped.
// Ports    :
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_stall                 hold IF/ID and block delivery
//   i_flush                 replace IF/ID contents with a bubble
//   i_redirect_en/_addr     load a new fetch PC (addr bits [1:0] forced to 0)
//   o_imem_req/_addr        fetch request and address (from state only)
//   i_imem_ack/_data        one-cycle response strobe with instruction word
//   o_id_valid/_pc/_inst    IF/ID register contents (inst = 0 when invalid)
// Revision : 1.0  initial release
// ============================================================================
module if_stage #(
  parameter int                       N_INST_ADDR = 32,
  parameter int                       N_INST_DATA = 32,
  parameter logic [N_INST_ADDR-1:0]   RESET_PC    = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_stall,
  input  logic                    i_flush,
  input  logic                    i_redirect_en,
  input  logic [N_INST_ADDR-1:0]  i_redirect_addr,
  output logic                    o_imem_req,
  output logic [N_INST_ADDR-1:0]  o_imem_addr,
  input  logic                    i_imem_ack,
  input  logic [N_INST_DATA-1:0]  i_imem_data,
  output logic                    o_id_valid,
  output logic [N_INST_ADDR-1:0]  o_id_pc,
  output logic [N_INST_DATA-1:0]  o_id_inst
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [N_INST_ADDR-1:0] C_PC_STEP   = N_INST_ADDR'(4);
  localparam logic [N_INST_ADDR-1:0] C_WORD_MASK = ~(N_INST_ADDR'(3));

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]             state_q,    state_d;
  logic [N_INST_ADDR-1:0] pc_q,       pc_d;
  logic [N_INST_ADDR-1:0] redir_pc_q, redir_pc_d;
  logic [N_INST_ADDR-1:0] buf_pc_q,   buf_pc_d;
  logic [N_INST_DATA-1:0] buf_inst_q, buf_inst_d;
  logic                   id_valid_q, id_valid_d;
  logic [N_INST_ADDR-1:0] id_pc_q,    id_pc_d;
  logic [N_INST_DATA-1:0] id_inst_q,  id_inst_d;

  // --------------------------------------------------------------------------
  // Shared decode terms
  // --------------------------------------------------------------------------
  logic [N_INST_ADDR-1:0] redir_tgt;
  logic [N_INST_ADDR-1:0] pc_inc;
  logic                   park;         // a delivery cannot enter IF/ID now
  logic                   accept;       // fetch returned and is kept
  logic                   hold_release; // buffered instruction may move on

  always_comb begin
    redir_tgt    = i_redirect_addr & C_WORD_MASK;
    pc_inc       = pc_q + C_PC_STEP;   // wraps modulo 2^N_INST_ADDR
    // A flush empties IF/ID this cycle, so any arriving instruction is parked
    // in the hold buffer exactly as a stall would, and nothing is lost.
    park         = i_stall | i_flush;
    accept       = (state_q == S_FETCH) & i_imem_ack & ~i_redirect_en;
    hold_release = (state_q == S_HOLD) & ~i_redirect_en & ~i_stall;
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          // A kept fetch that cannot be delivered goes to the hold buffer.
          if (!i_redirect_en && park) begin
            state_d = S_HOLD;
          end
        end else if (i_redirect_en) begin
          // Request still in flight: wait for it before using the target.
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        // Redirect wins over stall: the buffered instruction is dropped.
        if (i_redirect_en || !park) begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (i_imem_ack) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (pure function of state; address is the held PC)
  // --------------------------------------------------------------------------
  always_comb begin
    o_imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    o_imem_addr = pc_q;
  end

  // --------------------------------------------------------------------------
  // PC, pending-redirect and hold-buffer next values
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    case (state_q)
      S_RESET: begin
        if (i_redirect_en) begin
          pc_d = redir_tgt;
        end
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          if (i_redirect_en) begin
            pc_d = redir_tgt;          // returned data is dropped
          end else begin
            pc_d = pc_inc;
            if (park) begin
              buf_pc_d   = pc_q;
              buf_inst_d = i_imem_data;
            end
          end
        end else if (i_redirect_en) begin
          redir_pc_d = redir_tgt;
        end
      end
      S_HOLD: begin
        if (i_redirect_en) begin
          pc_d = redir_tgt;
        end
      end
      S_DRAIN: begin
        // Latest redirect wins, including one arriving with the ack.
        if (i_redirect_en) begin
          redir_pc_d = redir_tgt;
        end
        if (i_imem_ack) begin
          pc_d = i_redirect_en ? redir_tgt : redir_pc_q;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // IF/ID register next value: flush > stall > delivery > bubble
  // --------------------------------------------------------------------------
  always_comb begin
    id_valid_d = 1'b0;
    id_pc_d    = '0;
    id_inst_d  = '0;
    if (i_flush) begin
      id_valid_d = 1'b0;
    end else if (i_stall) begin
      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
    end else if (accept) begin
      id_valid_d = 1'b1;
      id_pc_d    = pc_q;
      id_inst_d  = i_imem_data;
    end else if (hold_release) begin
      id_valid_d = 1'b1;
      id_pc_d    = buf_pc_q;
      id_inst_d  = buf_inst_q;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q       <= RESET_PC;
      redir_pc_q <= '0;
      buf_pc_q   <= '0;
      buf_inst_q <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

  assign o_id_valid = id_valid_q;
  assign o_id_pc    = id_pc_q;
  assign o_id_inst  = id_inst_q;

endmodule
`default_nettype wire
